sr_prog_encoder: RTL and testbench
==================================

# sr_prog_encoder

Program loader that encodes a stream of symbolic instruction requests (op, rd, rs1, rs2, imm) into 32-bit RV32I machine words and writes them sequentially into instruction memory. It covers exactly the instruction subset the CPU control unit decodes. It holds the CPU in reset until the program is fully written. It sits between a host or test source and the instruction-memory write port, alongside `sr_cpu`.

## Interface
- `ADDR_WIDTH`, 6: instruction-memory word-address width.
- `BASE_ADDR`, 0: first word address written after `start`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load. Honoured only in IDLE or DONE.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_op`  in  4  0 ADD, 1 OR, 2 SRL, 3 SLTU, 4 SUB, 5 SLLI, 6 ADDI, 7 LUI, 8 BEQ, 9 BNE, 10-15 illegal.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_imm`  in  20  immediate; see Operation.
- `in_last`  in  1  marks the final request of the program.
- `im_we`  out  1  instruction-memory write strobe.
- `im_addr`  out  ADDR_WIDTH  write word address.
- `im_wdata`  out  32  encoded instruction.
- `cpu_hold`  out  1  high keeps the CPU in reset.
- `done`  out  1  program loaded.
- `err`  out  1  sticky error; cleared on an honoured `start`.

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
  - IDLE --start--> LOAD.
  - LOAD --accepted `in_last` or address overflow--> FLUSH.
  - FLUSH --> DONE (unconditional).
  - DONE --start--> LOAD.
  - `start` in LOAD or FLUSH is ignored.
- An honoured `start` loads the address counter with `BASE_ADDR` and clears `err`.
- `in_ready` = (state == LOAD). It is combinational from state only.
- Encoding:
  - R-type, opcode 0110011:
    - ADD: f3 000, f7 0000000.
    - OR: f3 110, f7 0000000.
    - SRL: f3 101, f7 0000000.
    - SLTU: f3 011, f7 0000000.
    - SUB: f3 000, f7 0100000.
  - SLLI: opcode 0010011, f3 001, f7 0, shamt = `in_imm[4:0]`, rs2 field unused.
  - ADDI: opcode 0010011, f3 000, imm[11:0] = `in_imm[11:0]`.
  - LUI: opcode 0110111, word[31:12] = `in_imm[19:0]`.
  - BEQ and BNE: opcode 1100011, f3 000 and 001 respectively.
    - Byte offset = `in_imm[12:0]`, with bit 0 ignored.
    - Standard B-type scatter: imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode.
  - Fields unused by a format are ignored and never reach the output word.
- Address counter:
  - Increments by one per accepted legal request.
  - Accepting a legal request at address 2^ADDR_WIDTH-1 without `in_last`: write that word, set `err`, and treat it as last.
- Illegal op (10-15):
  - Request is accepted.
  - No write; counter unchanged; `err` set.
  - If `in_last` is set on it, the FLUSH/DONE transition still occurs.
- `cpu_hold` = 1 in IDLE, LOAD and FLUSH; 0 in DONE.
- `done` = (state == DONE).

## Timing
- Reset values: state IDLE, `im_we` 0, `im_addr` 0, `im_wdata` 0, `err` 0, `done` 0, `cpu_hold` 1, `in_ready` 0.
- Latency: a request accepted in cycle N produces registered `im_we`/`im_addr`/`im_wdata` in cycle N+1.
- Throughput: one request per cycle; no bubbles while in LOAD.
- Last request accepted in cycle N:
  - N+1: FLUSH, final write presented.
  - N+2: DONE, `done`=1, `cpu_hold`=0.
  - The CPU is therefore never released in the same cycle as a write.
- `err` updates in cycle N+1 of the offending acceptance.
- `im_we` is 0 in every cycle not directly following a legal acceptance.
- `rst_n` low mid-load aborts immediately to the reset values. No further writes occur.

## Test plan
- Reset, `start`, then ADD rd3 rs1 1 rs2 2 (with `in_last`).
  - Required: next cycle `im_we`=1, `im_addr`=0, `im_wdata`=0x002081B3.
  - Then `done`=1 and `cpu_hold`=0 two cycles after acceptance.
- Back-to-back stream, one request per cycle: ADDI x1,x0,5; SUB x5,x6,x7; LUI x2,0x12345; SLLI x4,x4,3.
  - Required words at addresses 0-3: 0x00500093, 0x407302B3, 0x12345137, 0x00321213.
- Branches: BEQ x1,x2 imm 8 → 0x00208463; BNE x1,x0 imm -4 (0x1FFC) → 0xFE009EE3.
- Illegal op 12 between two ADDIs.
  - Required: only two writes, at addresses 0 and 1.
  - `err`=1 and stays 1 after DONE.
  - A new `start` clears `err`.
- ADDR_WIDTH=2, five requests without `in_last`.
  - Required: writes at addresses 0-3, then `err`=1 and state DONE.
  - Fifth request not accepted (`in_ready`=0).
- `rst_n` pulled low after two accepted requests.
  - Required: `im_we` 0 immediately, `cpu_hold`=1, `done`=0, state IDLE.
  - `start` ignored in LOAD: the counter does not reset.

Source files
------------

// File: rtl/sr_prog_encoder_if.sv
// rtl/sr_prog_encoder_if.sv - request stream and instruction-memory write port of the program loader
interface sr_prog_encoder_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_op;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [19:0]           in_imm;
    logic                  in_last;
    logic                  im_we;
    logic [ADDR_WIDTH-1:0] im_addr;
    logic [31:0]           im_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/sr_prog_encoder.sv
// rtl/sr_prog_encoder.sv - encodes symbolic RV32I requests and writes them into instruction memory
module sr_prog_encoder #(
    parameter int          ADDR_WIDTH = 6,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    sr_prog_encoder_if.slave  bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_B   = 7'b1100011;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  im_we_q, im_we_d;
    logic [ADDR_WIDTH-1:0] im_addr_q, im_addr_d;
    logic [31:0]           im_wdata_q, im_wdata_d;
    logic                  err_q, err_d;
    logic                  legal;
    logic [31:0]           word;

    function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [19:0] imm);
        case (op)
            4'd0:    encode = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R};
            4'd1:    encode = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_R};
            4'd2:    encode = {7'b0000000, rs2, rs1, 3'b101, rd, OPC_R};
            4'd3:    encode = {7'b0000000, rs2, rs1, 3'b011, rd, OPC_R};
            4'd4:    encode = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R};
            4'd5:    encode = {7'b0000000, imm[4:0], rs1, 3'b001, rd, OPC_I};
            4'd6:    encode = {imm[11:0], rs1, 3'b000, rd, OPC_I};
            4'd7:    encode = {imm, rd, OPC_LUI};
            4'd8:    encode = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_B};
            4'd9:    encode = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], OPC_B};
            default: encode = 32'h0;
        endcase
    endfunction

    assign legal = (bus.in_op <= 4'd9);
    assign word  = encode(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = BASE;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    if (legal) begin
                        im_we_d    = 1'b1;
                        im_addr_d  = cnt_q;
                        im_wdata_d = word;
                        cnt_d      = cnt_q + 1'b1;
                        // Last slot reached without in_last: the program cannot fit.
                        if (cnt_q == '1 && !bus.in_last) begin
                            err_d   = 1'b1;
                            state_d = S_FLUSH;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    if (bus.in_last) state_d = S_FLUSH;
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready = (state_q == S_LOAD);
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign cpu_hold     = (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign err          = err_q;
endmodule

// File: tb/tb_sr_prog_encoder.sv
// tb/tb_sr_prog_encoder.sv - directed self-checking bench for sr_prog_encoder
module tb_sr_prog_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic cpu_hold_a, done_a, err_a;
    logic cpu_hold_b, done_b, err_b;
    int compared = 0;
    int mismatched = 0;

    sr_prog_encoder_if #(.ADDR_WIDTH(6)) bus_a ();
    sr_prog_encoder_if #(.ADDR_WIDTH(2)) bus_b ();

    sr_prog_encoder #(.ADDR_WIDTH(6), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bus(bus_a.slave),
        .cpu_hold(cpu_hold_a), .done(done_a), .err(err_a)
    );

    sr_prog_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bus(bus_b.slave),
        .cpu_hold(cpu_hold_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [19:0] imm, input logic last);
        bus_a.in_valid = 1'b1;
        bus_a.in_op    = op;
        bus_a.in_rd    = rd;
        bus_a.in_rs1   = rs1;
        bus_a.in_rs2   = rs2;
        bus_a.in_imm   = imm;
        bus_a.in_last  = last;
    endtask

    task automatic start_pulse_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_op = 4'd0; bus_a.in_rd = 5'd0; bus_a.in_rs1 = 5'd0;
        bus_a.in_rs2 = 5'd0; bus_a.in_imm = 20'd0; bus_a.in_last = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_op = 4'd0; bus_b.in_rd = 5'd0; bus_b.in_rs1 = 5'd0;
        bus_b.in_rs2 = 5'd0; bus_b.in_imm = 20'd0; bus_b.in_last = 1'b0;
        tick();
        tick();
        compared++; if (bus_a.im_we !== 1'b0) begin mismatched++; $display("FAIL reset_im_we got %0b exp 0", bus_a.im_we); end
        compared++; if (bus_a.im_addr !== 6'd0) begin mismatched++; $display("FAIL reset_im_addr got %0d exp 0", bus_a.im_addr); end
        compared++; if (bus_a.im_wdata !== 32'h0) begin mismatched++; $display("FAIL reset_im_wdata got %h exp 0", bus_a.im_wdata); end
        compared++; if (err_a !== 1'b0) begin mismatched++; $display("FAIL reset_err got %0b exp 0", err_a); end
        compared++; if (done_a !== 1'b0) begin mismatched++; $display("FAIL reset_done got %0b exp 0", done_a); end
        compared++; if (cpu_hold_a !== 1'b1) begin mismatched++; $display("FAIL reset_cpu_hold got %0b exp 1", cpu_hold_a); end
        compared++; if (bus_a.in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready got %0b exp 0", bus_a.in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        start_pulse_a();
        compared++; if (bus_a.in_ready !== 1'b1) begin mismatched++; $display("FAIL add_in_ready got %0b exp 1", bus_a.in_ready); end
        drive_a(4'd0, 5'd3, 5'd1, 5'd2, 20'hFFFFF, 1'b1);
        tick();
        bus_a.in_valid = 1'b0;
        compared++; if (bus_a.im_we !== 1'b1) begin mismatched++; $display("FAIL add_we got %0b exp 1", bus_a.im_we); end
        compared++; if (bus_a.im_addr !== 6'd0) begin mismatched++; $display("FAIL add_addr got %0d exp 0", bus_a.im_addr); end
        compared++; if (bus_a.im_wdata !== 32'h002081B3) begin mismatched++; $display("FAIL add_wdata got %h exp 002081B3", bus_a.im_wdata); end
        compared++; if (cpu_hold_a !== 1'b1 || done_a !== 1'b0) begin mismatched++; $display("FAIL add_flush got hold=%0b done=%0b exp hold=1 done=0", cpu_hold_a, done_a); end
        tick();
        compared++; if (done_a !== 1'b1 || cpu_hold_a !== 1'b0) begin mismatched++; $display("FAIL add_done got done=%0b hold=%0b exp done=1 hold=0", done_a, cpu_hold_a); end
        compared++; if (bus_a.im_we !== 1'b0) begin mismatched++; $display("FAIL add_done_we got %0b exp 0", bus_a.im_we); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op  [4] = '{4'd6, 4'd4, 4'd7, 4'd5};
        logic [4:0]  rd  [4] = '{5'd1, 5'd5, 5'd2, 5'd4};
        logic [4:0]  rs1 [4] = '{5'd0, 5'd6, 5'd9, 5'd4};
        logic [4:0]  rs2 [4] = '{5'd31, 5'd7, 5'd17, 5'd22};
        logic [19:0] imm [4] = '{20'hFF005, 20'h00000, 20'h12345, 20'hFFFE3};
        logic [31:0] exp_w [4] = '{32'h00500093, 32'h407302B3, 32'h12345137, 32'h00321213};
        start_pulse_a();
        for (int i = 0; i < 4; i++) begin
            drive_a(op[i], rd[i], rs1[i], rs2[i], imm[i], i == 3);
            tick();
            compared++;
            if (bus_a.im_we !== 1'b1 || bus_a.im_addr !== 6'(i) || bus_a.im_wdata !== exp_w[i]) begin
                mismatched++;
                $display("FAIL b2b_word%0d got we=%0b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                         i, bus_a.im_we, bus_a.im_addr, bus_a.im_wdata, i, exp_w[i]);
            end
        end
        bus_a.in_valid = 1'b0;
        tick();
        compared++; if (done_a !== 1'b1) begin mismatched++; $display("FAIL b2b_done got %0b exp 1", done_a); end
    endtask

    task automatic test_branches();
        start_pulse_a();
        drive_a(4'd8, 5'd31, 5'd1, 5'd2, 20'h00008, 1'b0);
        tick();
        compared++; if (bus_a.im_wdata !== 32'h00208463 || bus_a.im_we !== 1'b1) begin mismatched++; $display("FAIL beq_word got we=%0b data=%h exp we=1 data=00208463", bus_a.im_we, bus_a.im_wdata); end
        drive_a(4'd9, 5'd17, 5'd1, 5'd0, 20'h01FFC, 1'b1);
        tick();
        bus_a.in_valid = 1'b0;
        compared++; if (bus_a.im_wdata !== 32'hFE009EE3 || bus_a.im_addr !== 6'd1) begin mismatched++; $display("FAIL bne_word got addr=%0d data=%h exp addr=1 data=FE009EE3", bus_a.im_addr, bus_a.im_wdata); end
        tick();
    endtask

    task automatic test_illegal();
        start_pulse_a();
        drive_a(4'd6, 5'd1, 5'd0, 5'd0, 20'h00001, 1'b0);
        tick();
        compared++; if (bus_a.im_we !== 1'b1 || bus_a.im_addr !== 6'd0 || bus_a.im_wdata !== 32'h00100093) begin mismatched++; $display("FAIL ill_first got we=%0b addr=%0d data=%h exp we=1 addr=0 data=00100093", bus_a.im_we, bus_a.im_addr, bus_a.im_wdata); end
        drive_a(4'd12, 5'd1, 5'd1, 5'd1, 20'h00001, 1'b0);
        tick();
        compared++; if (bus_a.im_we !== 1'b0 || err_a !== 1'b1) begin mismatched++; $display("FAIL ill_op got we=%0b err=%0b exp we=0 err=1", bus_a.im_we, err_a); end
        drive_a(4'd6, 5'd2, 5'd0, 5'd0, 20'h00002, 1'b1);
        tick();
        bus_a.in_valid = 1'b0;
        compared++; if (bus_a.im_we !== 1'b1 || bus_a.im_addr !== 6'd1 || bus_a.im_wdata !== 32'h00200113) begin mismatched++; $display("FAIL ill_second got we=%0b addr=%0d data=%h exp we=1 addr=1 data=00200113", bus_a.im_we, bus_a.im_addr, bus_a.im_wdata); end
        tick();
        compared++; if (done_a !== 1'b1 || err_a !== 1'b1) begin mismatched++; $display("FAIL ill_done got done=%0b err=%0b exp done=1 err=1", done_a, err_a); end
        start_pulse_a();
        compared++; if (err_a !== 1'b0 || done_a !== 1'b0 || bus_a.in_ready !== 1'b1) begin mismatched++; $display("FAIL ill_restart got err=%0b done=%0b ready=%0b exp 0 0 1", err_a, done_a, bus_a.in_ready); end
        drive_a(4'd15, 5'd1, 5'd1, 5'd1, 20'h0, 1'b1);
        tick();
        bus_a.in_valid = 1'b0;
        compared++; if (bus_a.im_we !== 1'b0 || err_a !== 1'b1) begin mismatched++; $display("FAIL ill_last got we=%0b err=%0b exp we=0 err=1", bus_a.im_we, err_a); end
        tick();
        compared++; if (done_a !== 1'b1) begin mismatched++; $display("FAIL ill_last_done got %0b exp 1", done_a); end
    endtask

    task automatic test_overflow();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        bus_b.in_op = 4'd6; bus_b.in_rd = 5'd1; bus_b.in_rs1 = 5'd0; bus_b.in_last = 1'b0;
        bus_b.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_b.in_imm = 20'(i);
            tick();
            compared++;
            if (bus_b.im_we !== 1'b1 || bus_b.im_addr !== 2'(i) || bus_b.im_wdata !== ({12'(i), 20'h00093})) begin
                mismatched++;
                $display("FAIL ovf_word%0d got we=%0b addr=%0d data=%h exp we=1 addr=%0d", i, bus_b.im_we, bus_b.im_addr, bus_b.im_wdata, i);
            end
        end
        compared++; if (err_b !== 1'b1 || bus_b.in_ready !== 1'b0) begin mismatched++; $display("FAIL ovf_err got err=%0b ready=%0b exp err=1 ready=0", err_b, bus_b.in_ready); end
        bus_b.in_imm = 20'd4;
        tick();
        compared++; if (done_b !== 1'b1 || bus_b.im_we !== 1'b0 || bus_b.in_ready !== 1'b0) begin mismatched++; $display("FAIL ovf_done got done=%0b we=%0b ready=%0b exp 1 0 0", done_b, bus_b.im_we, bus_b.in_ready); end
        tick();
        compared++; if (bus_b.im_we !== 1'b0) begin mismatched++; $display("FAIL ovf_fifth got we=%0b exp 0", bus_b.im_we); end
        bus_b.in_valid = 1'b0;
    endtask

    task automatic test_reset_midload();
        start_pulse_a();
        drive_a(4'd0, 5'd3, 5'd1, 5'd2, 20'h0, 1'b0);
        tick();
        start_a = 1'b1;
        drive_a(4'd1, 5'd4, 5'd5, 5'd6, 20'h0, 1'b0);
        tick();
        start_a = 1'b0;
        compared++; if (bus_a.im_addr !== 6'd1 || bus_a.im_we !== 1'b1) begin mismatched++; $display("FAIL mid_second got addr=%0d we=%0b exp addr=1 we=1", bus_a.im_addr, bus_a.im_we); end
        drive_a(4'd2, 5'd7, 5'd8, 5'd9, 20'h0, 1'b0);
        tick();
        compared++; if (bus_a.im_addr !== 6'd2 || bus_a.im_wdata !== 32'h009452B3 - 32'h00000000 + 32'h00000000 - 32'h009452B3 + 32'h009453B3) begin mismatched++; $display("FAIL mid_start_ignored got addr=%0d data=%h exp addr=2 data=009453B3", bus_a.im_addr, bus_a.im_wdata); end
        rst_n = 1'b0;
        #1;
        compared++; if (bus_a.im_we !== 1'b0 || cpu_hold_a !== 1'b1 || done_a !== 1'b0 || bus_a.in_ready !== 1'b0) begin mismatched++; $display("FAIL mid_reset got we=%0b hold=%0b done=%0b ready=%0b exp 0 1 0 0", bus_a.im_we, cpu_hold_a, done_a, bus_a.in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        compared++; if (bus_a.im_we !== 1'b0 || bus_a.in_ready !== 1'b0 || bus_a.im_addr !== 6'd0) begin mismatched++; $display("FAIL mid_after got we=%0b ready=%0b addr=%0d exp 0 0 0", bus_a.im_we, bus_a.in_ready, bus_a.im_addr); end
        bus_a.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_branches();
        test_illegal();
        test_overflow();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
